// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel arbitrating stream mux, registered output.
// Fixed-priority or round-robin grant; a burst holds the grant until in_last.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-burst (1 for single beats)
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered data of the accepted beat
//   out_sel    channel index that supplied out_data
//   out_last   registered in_last of the accepted beat
//   out_valid  output register holds a beat
//   out_ready  sink accepts the beat
module stream_mux_arb #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int RR       = 1,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SELW-1:0]     r_lock_ch;
  logic [SELW-1:0]     w_lock_nxt;
  logic [SELW-1:0]     r_ptr;
  logic [SELW-1:0]     w_ptr_nxt;

  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_sel;
  logic                r_out_last;
  logic                r_out_valid;

  logic                w_can_load;
  logic [CHANNELS-1:0] w_arb_gnt;
  logic [SELW-1:0]     w_arb_idx;
  logic [CHANNELS-1:0] w_lock_oh;
  logic [CHANNELS-1:0] w_gnt;
  logic [SELW-1:0]     w_gnt_idx;
  logic [CHANNELS-1:0] w_ready;
  logic                w_accept;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_last;
  logic [SELW-1:0]     w_idx_inc;

  assign w_can_load = !r_out_valid || out_ready;

  // Search starts at r_ptr (RR) or 0 (fixed) and wraps once.
  // r_ptr < CHANNELS always, so a single subtract is enough.
  always_comb begin : arb
    logic found;
    int   c;
    found     = 1'b0;
    c         = 0;
    w_arb_gnt = '0;
    w_arb_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = (RR != 0) ? (int'(r_ptr) + i) : i;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (!found && in_valid[c]) begin
        found        = 1'b1;
        w_arb_gnt[c] = 1'b1;
        w_arb_idx    = SELW'(c);
      end
    end
  end

  always_comb begin : lock_dec
    w_lock_oh = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_lock_oh[k] = (r_lock_ch == SELW'(k));
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OPEN;
      r_lock_ch <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // FSM: next state
  always_comb begin : fsm_nxt
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    unique case (r_state)
      ST_OPEN: begin
        if (w_accept && !w_sel_last) begin
          w_state_nxt = ST_LOCKED;
          w_lock_nxt  = w_gnt_idx;
        end
      end
      ST_LOCKED: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = ST_OPEN;
        end
      end
    endcase
  end

  // FSM: outputs. A locked burst owns the port even through
  // bubbles, so other channels stay stalled.
  always_comb begin : fsm_out
    w_gnt     = w_arb_gnt;
    w_gnt_idx = w_arb_idx;
    unique case (r_state)
      ST_OPEN: begin
        w_gnt     = w_arb_gnt;
        w_gnt_idx = w_arb_idx;
      end
      ST_LOCKED: begin
        w_gnt     = w_lock_oh & in_valid;
        w_gnt_idx = r_lock_ch;
      end
    endcase
  end

  assign w_ready  = w_gnt & {CHANNELS{w_can_load}};
  assign w_accept = |w_ready;
  assign in_ready = w_ready & {CHANNELS{rst_n}};

  always_comb begin : sel_mux
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_gnt[k]) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
        w_sel_last = in_last[k];
      end
    end
  end

  assign w_idx_inc =
    (w_gnt_idx == SELW'(CHANNELS - 1)) ? '0
                                       : w_gnt_idx + SELW'(1);

  // Pointer advances only when a burst (or single beat) completes.
  always_comb begin : ptr_nxt
    w_ptr_nxt = r_ptr;
    if ((RR != 0) && w_accept && w_sel_last) begin
      w_ptr_nxt = w_idx_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_gnt_idx;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed bench for stream_mux_arb.
// Three instances: RR/4ch, fixed/4ch, RR/3ch.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic [19:0] rr_data;
  logic [3:0]  rr_valid, rr_last, rr_ready;
  logic [4:0]  rr_odata;
  logic [1:0]  rr_osel;
  logic        rr_olast, rr_ovalid, rr_oready;

  logic [19:0] fp_data;
  logic [3:0]  fp_valid, fp_last, fp_ready;
  logic [4:0]  fp_odata;
  logic [1:0]  fp_osel;
  logic        fp_olast, fp_ovalid, fp_oready;

  logic [14:0] c3_data;
  logic [2:0]  c3_valid, c3_last, c3_ready;
  logic [4:0]  c3_odata;
  logic [1:0]  c3_osel;
  logic        c3_olast, c3_ovalid, c3_oready;

  stream_mux_arb #(.WIDTH(5), .CHANNELS(4), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(rr_data), .in_valid(rr_valid),
    .in_last(rr_last), .in_ready(rr_ready),
    .out_data(rr_odata), .out_sel(rr_osel),
    .out_last(rr_olast), .out_valid(rr_ovalid),
    .out_ready(rr_oready)
  );

  stream_mux_arb #(.WIDTH(5), .CHANNELS(4), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(fp_data), .in_valid(fp_valid),
    .in_last(fp_last), .in_ready(fp_ready),
    .out_data(fp_odata), .out_sel(fp_osel),
    .out_last(fp_olast), .out_valid(fp_ovalid),
    .out_ready(fp_oready)
  );

  stream_mux_arb #(.WIDTH(5), .CHANNELS(3), .RR(1)) u_c3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(c3_data), .in_valid(c3_valid),
    .in_last(c3_last), .in_ready(c3_ready),
    .out_data(c3_odata), .out_sel(c3_osel),
    .out_last(c3_olast), .out_valid(c3_ovalid),
    .out_ready(c3_oready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rr_valid  = 4'hF;
    rr_last   = 4'hF;
    rr_data   = {5'd13, 5'd12, 5'd11, 5'd10};
    rr_oready = 1'b1;
    fp_valid  = '0;
    fp_last   = 4'hF;
    fp_data   = '0;
    fp_oready = 1'b1;
    c3_valid  = '0;
    c3_last   = 3'h7;
    c3_data   = '0;
    c3_oready = 1'b1;

    // reset held with all channels valid
    tick();
    tick();
    chk("rst_ready", 32'(rr_ready), 32'h0);
    chk("rst_ovalid", 32'(rr_ovalid), 32'h0);
    chk("rst_odata", 32'(rr_odata), 32'h0);
    chk("rst_osel", 32'(rr_osel), 32'h0);
    chk("rst_olast", 32'(rr_olast), 32'h0);

    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(rr_ready), 32'h1);
    tick();
    chk("first_sel", 32'(rr_osel), 32'h0);
    chk("first_data", 32'(rr_odata), 32'd10);
    chk("first_valid", 32'(rr_ovalid), 32'h1);

    // round-robin fairness
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rr_sel", 32'(rr_osel), 32'(i % 4));
      chk("rr_data", 32'(rr_odata), 32'(10 + (i % 4)));
      chk("rr_valid", 32'(rr_ovalid), 32'h1);
    end

    // backpressure: ptr=1, load 1F from ch1
    rr_valid = 4'b0010;
    rr_data  = {5'd13, 5'd12, 5'h1F, 5'd10};
    tick();
    chk("bp_load", 32'(rr_odata), 32'h1F);
    rr_oready = 1'b0;
    rr_valid  = 4'b0100;
    #1;
    chk("bp_ready0", 32'(rr_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", 32'(rr_odata), 32'h1F);
      chk("bp_ready", 32'(rr_ready), 32'h0);
      chk("bp_valid", 32'(rr_ovalid), 32'h1);
    end
    rr_oready = 1'b1;
    #1;
    chk("bp_resume", 32'(rr_ready), 32'h4);
    tick();
    chk("bp_new_data", 32'(rr_odata), 32'd12);
    chk("bp_new_sel", 32'(rr_osel), 32'h2);
    rr_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(rr_ovalid), 32'h0);
    chk("drain_hold", 32'(rr_odata), 32'd12);

    // ptr is 3; one ch1 beat moves it to 2
    rr_valid = 4'b0010;
    rr_data  = {5'd13, 5'd12, 5'd5, 5'd10};
    tick();
    chk("pre_sel", 32'(rr_osel), 32'h1);

    // burst lock: ch2 3 beats with bubbles, ch0 always valid
    rr_valid = 4'b0101;
    rr_last  = 4'b1011;
    rr_data  = {5'd13, 5'd20, 5'd5, 5'd10};
    #1;
    chk("b1_ready", 32'(rr_ready), 32'h4);
    tick();
    chk("b1_data", 32'(rr_odata), 32'd20);
    chk("b1_last", 32'(rr_olast), 32'h0);
    rr_valid = 4'b0001;
    #1;
    chk("bub1_ready", 32'(rr_ready), 32'h0);
    tick();
    chk("bub1_ovalid", 32'(rr_ovalid), 32'h0);
    rr_valid = 4'b0101;
    rr_data  = {5'd13, 5'd21, 5'd5, 5'd10};
    #1;
    chk("b2_ready", 32'(rr_ready), 32'h4);
    tick();
    chk("b2_data", 32'(rr_odata), 32'd21);
    rr_valid = 4'b0001;
    #1;
    chk("bub2_ready", 32'(rr_ready), 32'h0);
    tick();
    rr_valid = 4'b0101;
    rr_last  = 4'b1111;
    rr_data  = {5'd13, 5'd22, 5'd5, 5'd10};
    #1;
    chk("b3_ready", 32'(rr_ready), 32'h4);
    tick();
    chk("b3_data", 32'(rr_odata), 32'd22);
    chk("b3_last", 32'(rr_olast), 32'h1);
    chk("b3_ptr", 32'(u_rr.r_ptr), 32'h3);
    rr_valid = 4'b0001;
    #1;
    chk("post_ready", 32'(rr_ready), 32'h1);
    tick();
    chk("post_sel", 32'(rr_osel), 32'h0);
    rr_valid = 4'b0000;

    // fixed priority, ch1 and ch3 valid
    fp_valid = 4'b1010;
    fp_data  = {5'd9, 5'd0, 5'd7, 5'd0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready", 32'(fp_ready), 32'h2);
      tick();
      chk("fp_sel", 32'(fp_osel), 32'h1);
      chk("fp_data", 32'(fp_odata), 32'd7);
    end
    fp_valid = 4'b1000;
    #1;
    chk("fp_ready3", 32'(fp_ready), 32'h8);
    tick();
    chk("fp_sel3", 32'(fp_osel), 32'h3);
    chk("fp_data3", 32'(fp_odata), 32'd9);
    fp_valid = 4'b0000;

    // three channels: wrap 2 -> 0
    c3_valid = 3'b111;
    c3_data  = {5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c3_sel", 32'(c3_osel), 32'(i % 3));
      chk("c3_data", 32'(c3_odata), 32'((i % 3) + 1));
    end

    // ptr=2: start a burst on ch2, then reset mid-burst
    c3_valid = 3'b100;
    c3_last  = 3'b011;
    tick();
    chk("c3_lock_sel", 32'(c3_osel), 32'h2);
    c3_valid = 3'b011;
    #1;
    chk("c3_locked", 32'(c3_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("c3_rst_ovalid", 32'(c3_ovalid), 32'h0);
    chk("c3_rst_ready", 32'(c3_ready), 32'h0);
    chk("c3_rst_sel", 32'(c3_osel), 32'h0);
    tick();
    rst_n    = 1'b1;
    c3_valid = 3'b110;
    c3_last  = 3'b111;
    #1;
    chk("c3_open_ready", 32'(c3_ready), 32'h2);
    tick();
    chk("c3_open_sel", 32'(c3_osel), 32'h1);
    chk("c3_open_data", 32'(c3_odata), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
